rvfi_retire_buffer: RTL and testbench



---
 rtl/rvfi_retire_buffer_if.sv | 26 ++
 rtl/rvfi_retire_buffer.sv | 102 ++++++++++
 tb/tb_rvfi_retire_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rvfi_retire_buffer_if.sv
// rtl/rvfi_retire_buffer_if.sv - retire-lane input and RVFI output bundle for rvfi_retire_buffer
interface rvfi_retire_buffer_if #(
  parameter int NIN   = 2,
  parameter int NOUT  = 1,
  parameter int PKT_W = 64,
  parameter int DEPTH = 8
);
  logic [NIN-1:0]               in_valid;
  logic [NIN*PKT_W-1:0]         in_pkt;
  logic                         in_ready;
  logic                         in_flush;
  logic [NOUT-1:0]              rvfi_valid;
  logic [NOUT*64-1:0]           rvfi_order;
  logic [NOUT*PKT_W-1:0]        rvfi_pkt;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport slave (
    input  in_valid, in_pkt, in_flush,
    output in_ready, rvfi_valid, rvfi_order, rvfi_pkt, occupancy
  );

  modport master (
    output in_valid, in_pkt, in_flush,
    input  in_ready, rvfi_valid, rvfi_order, rvfi_pkt, occupancy
  );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// rtl/rvfi_retire_buffer.sv - compacting retire FIFO feeding RVFI lanes with rvfi_order assignment
// Optional stall_cycles counter enabled by RVFI_STALL_CNT_EN.
module rvfi_retire_buffer #(
  parameter int NIN   = 2,
  parameter int NOUT  = 1,
  parameter int PKT_W = 64,
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  rvfi_retire_buffer_if.slave   bus
`ifdef RVFI_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [63:0]      r_order;

  logic             w_ready;
  logic             w_accept;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_k;
  logic [AW-1:0]    w_slot [NIN];

  // Ready depends on registered count only, so the core sees no same-cycle pop credit.
  assign w_ready  = (DEPTH - int'(r_count)) >= NIN;
  assign w_accept = w_ready & (|bus.in_valid) & ~bus.in_flush;
  assign w_k      = (int'(r_count) < NOUT) ? r_count : CW'(NOUT);

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NIN; i++) begin
      w_slot[i] = w_pop[AW-1:0];
      w_pop     = w_pop + CW'(bus.in_valid[i]);
    end
  end

  always_comb begin
    bus.rvfi_valid = '0;
    bus.rvfi_order = '0;
    bus.rvfi_pkt   = '0;
    for (int j = 0; j < NOUT; j++) begin
      if (CW'(j) < w_k) begin
        bus.rvfi_valid[j]               = 1'b1;
        bus.rvfi_order[j*64 +: 64]      = r_order + 64'(j);
        bus.rvfi_pkt[j*PKT_W +: PKT_W]  = r_mem[r_head + AW'(j)];
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.occupancy = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_order <= '0;
    end else begin
      // Presented lanes are always consumed, flush or not, so order keeps advancing.
      r_order <= r_order + 64'(w_k);
      if (bus.in_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + AW'(w_k);
        r_count <= r_count + (w_accept ? w_pop : '0) - w_k;
        if (w_accept) begin
          r_tail <= r_tail + AW'(w_pop);
          for (int i = 0; i < NIN; i++) begin
            if (bus.in_valid[i]) r_mem[r_tail + w_slot[i]] <= bus.in_pkt[i*PKT_W +: PKT_W];
          end
        end
      end
    end
  end

`ifdef RVFI_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if ((|bus.in_valid) & ~w_ready & ~bus.in_flush & (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// tb/tb_rvfi_retire_buffer.sv - scoreboard bench for rvfi_retire_buffer against a queue-based model
module tb_rvfi_retire_buffer;
  localparam int NIN   = 2;
  localparam int NOUT  = 1;
  localparam int PKT_W = 8;
  localparam int DEPTH = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rvfi_retire_buffer_if #(.NIN(NIN), .NOUT(NOUT), .PKT_W(PKT_W), .DEPTH(DEPTH)) bus ();

`ifdef RVFI_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  rvfi_retire_buffer #(.NIN(NIN), .NOUT(NOUT), .PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef RVFI_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic [63:0]      order;
  } exp_t;

  exp_t             exp_q [$];
  exp_t             mon_e;
  logic [PKT_W-1:0] mq [$];
  logic [63:0]      m_order;
  logic [31:0]      m_stall;
  int               checks = 0;
  int               errors = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.rvfi_valid[0]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pkt %0h order %0h expected no output", bus.rvfi_pkt, bus.rvfi_order);
      end else begin
        mon_e = exp_q.pop_front();
        check64("rvfi_pkt", bus.rvfi_pkt, mon_e.pkt);
        check64("rvfi_order", bus.rvfi_order, mon_e.order);
      end
    end
  end

  // One clock of stimulus; called just after a rising edge when the model mirrors buffer contents.
  task automatic cycle(input logic [NIN-1:0] v, input logic [NIN*PKT_W-1:0] p, input logic f, output bit acc);
    int  k;
    bit  rdy;
    bus.in_valid = v;
    bus.in_pkt   = p;
    bus.in_flush = f;
    rdy = (DEPTH - mq.size()) >= NIN;
    k   = (mq.size() < NOUT) ? mq.size() : NOUT;
    for (int j = 0; j < k; j++) exp_q.push_back('{pkt: mq[j], order: m_order + 64'(j)});
    #1;
    check64("in_ready", 64'(bus.in_ready), 64'(rdy));
    check64("occupancy", 64'(bus.occupancy), 64'(mq.size()));
    check64("rvfi_valid", 64'(bus.rvfi_valid), 64'(k > 0));
    if (k == 0) begin
      check64("idle_pkt", 64'(bus.rvfi_pkt), 64'd0);
      check64("idle_order", bus.rvfi_order, 64'd0);
    end
    if (v != 0 && !rdy && !f && m_stall != 32'hFFFF_FFFF) m_stall++;
    acc = rdy && (v != 0) && !f;
    for (int j = 0; j < k; j++) void'(mq.pop_front());
    m_order += 64'(k);
    if (f) mq.delete();
    else if (acc) begin
      for (int i = 0; i < NIN; i++) if (v[i]) mq.push_back(p[i*PKT_W +: PKT_W]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, a);
  endtask

  task automatic do_reset();
    #2;
    reset_n      = 1'b0;
    bus.in_valid = '0;
    bus.in_pkt   = '0;
    bus.in_flush = 1'b0;
    #1;
    check64("reset_occupancy", 64'(bus.occupancy), 64'd0);
    check64("reset_rvfi_valid", 64'(bus.rvfi_valid), 64'd0);
    check64("reset_rvfi_order", bus.rvfi_order, 64'd0);
    check64("reset_rvfi_pkt", 64'(bus.rvfi_pkt), 64'd0);
    check64("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef RVFI_STALL_CNT_EN
    check64("reset_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    mq.delete();
    exp_q.delete();
    m_order = '0;
    m_stall = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_stall();
`ifdef RVFI_STALL_CNT_EN
    check64("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
  endtask

  initial begin
    bit                   a;
    int                   tries;
    logic [NIN*PKT_W-1:0] grp;
    bus.in_valid = '0;
    bus.in_pkt   = '0;
    bus.in_flush = 1'b0;
    m_order      = '0;
    m_stall      = '0;
    do_reset();

    cycle(2'b11, {8'h11, 8'h22}, 1'b0, a);
    idle(4);

    cycle(2'b10, {8'h33, 8'h00}, 1'b0, a);
    idle(3);

    // Back-to-back 2-lane groups, held until the model says they were taken.
    for (int g = 0; g < 8; g++) begin
      grp   = {8'(8'h40 + 2*g + 1), 8'(8'h40 + 2*g)};
      tries = 0;
      a     = 1'b0;
      while (!a && tries < 20) begin
        cycle(2'b11, grp, 1'b0, a);
        tries++;
      end
      if (!a) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: group %0d not accepted after %0d cycles", g, tries);
      end
    end
    idle(10);
    check_stall();

    do_reset();
    cycle(2'b11, {8'h55, 8'h66}, 1'b0, a);
    cycle(2'b11, {8'h77, 8'h88}, 1'b1, a);
    cycle(2'b01, {8'h00, 8'h99}, 1'b0, a);
    idle(3);

    do_reset();
    force dut.r_order = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_order;
    m_order = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(2'b11, {8'hA1, 8'hA0}, 1'b0, a);
    idle(4);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle(NIN'($urandom_range(0, 3)), NIN*PKT_W'($urandom), ($urandom_range(0, 19) == 0), a);
      if (n == 200) begin
        check_stall();
        do_reset();
      end
    end
    idle(8);
    check_stall();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
